// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, fixed-latency data memory access.
// Misaligned or illegal-size requests are rejected with a one-cycle error response.
module load_store_unit #(
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } state_t;

    localparam logic [2:0] RD_CNT = 3'(READ_LATENCY - 1);
    localparam logic [2:0] WR_CNT = 3'(WRITE_LATENCY - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic       wr_q;
    logic       misaligned;
    logic [2:0] size_mask;

    always_comb begin
        size_mask = 3'b111;
        unique case (req_size)
            2'b00:   size_mask = 3'b001;
            2'b01:   size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
        misaligned = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_nx     = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = misaligned ? ERR : ISSUE;
            end
            ISSUE: begin
                mem_memread  = ~wr_q;
                mem_memwrite = wr_q;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0)
                    state_nx = RESP;
            end
            RESP, ERR: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset is synchronous, so mask the outputs during the first reset cycle too
        if (reset) begin
            req_ready    = 1'b0;
            resp_valid   = 1'b0;
            mem_memread  = 1'b0;
            mem_memwrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            wr_q            <= 1'b0;
            resp_rdata      <= 32'd0;
            resp_misaligned <= 1'b0;
            mem_addr        <= 32'd0;
            mem_write_data  <= 32'd0;
            mem_sign_mask   <= 4'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            resp_misaligned <= 1'b1;
                            resp_rdata      <= 32'd0;
                        end else begin
                            wr_q           <= req_write;
                            mem_addr       <= req_addr;
                            mem_write_data <= req_wdata;
                            mem_sign_mask  <= {req_signed & ~req_write,
                                               size_mask};
                        end
                    end
                end
                ISSUE: cnt <= wr_q ? WR_CNT : RD_CNT;
                WAIT: begin
                    if (cnt == 3'd0) begin
                        resp_misaligned <= 1'b0;
                        resp_rdata      <= wr_q ? 32'd0 : mem_read_data;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus scoreboard queue,
// with hand sequences for back-to-back requests and mid-transaction reset.
module tb_load_store_unit;

    localparam int RL = 3;
    localparam int WL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_misaligned(resp_misaligned),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] mdata;
        logic        mis;
        logic [3:0]  mask;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
        int   nstb;
    } exp_t;

    exp_t        q[$];
    vec_t        cur;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_acc = -1;
    int          last_resp = -1;
    bit          pend = 1'b0;
    int          pend_cyc = 0;
    logic [31:0] pend_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not match expectation", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pend = 1'b0;
            mem_read_data = 32'd0;
        end else begin
            if (q.size() != 0)
                chk("ready_busy", {31'd0, req_ready}, 32'd0);
            if (req_valid && req_ready) begin
                q.push_back('{cur, cyc, 0});
                last_acc = cyc;
            end
            if (mem_memread || mem_memwrite) begin
                if (q.size() == 0) begin
                    fail("strobe_without_request");
                end else begin
                    q[0].nstb++;
                    chk("issue_cycle", cyc, q[0].acc + 1);
                    chk("memread", {31'd0, mem_memread}, {31'd0, ~q[0].v.wr});
                    chk("memwrite", {31'd0, mem_memwrite}, {31'd0, q[0].v.wr});
                    chk("mem_addr", mem_addr, q[0].v.addr);
                    chk("sign_mask", {28'd0, mem_sign_mask}, {28'd0, q[0].v.mask});
                    if (q[0].v.wr) begin
                        chk("mem_wdata", mem_write_data, q[0].v.wdata);
                    end else begin
                        pend      = 1'b1;
                        pend_cyc  = cyc + RL;
                        pend_data = q[0].v.mdata;
                    end
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_resp");
                end else begin
                    e = q.pop_front();
                    chk("resp_mis", {31'd0, resp_misaligned}, {31'd0, e.v.mis});
                    chk("resp_rdata", resp_rdata,
                        (e.v.wr || e.v.mis) ? 32'd0 : e.v.mdata);
                    chk("resp_latency", cyc - e.acc,
                        e.v.mis ? 1 : ((e.v.wr ? WL : RL) + 2));
                    chk("strobe_count", e.nstb, e.v.mis ? 0 : 1);
                    if (!e.v.mis)
                        chk("mem_addr_hold", mem_addr, e.v.addr);
                    last_resp = cyc;
                end
            end
            mem_read_data = (pend && cyc == pend_cyc) ? pend_data
                          : (32'hA5A5_0000 | 32'(cyc[15:0]));
        end
    end

    task automatic drive(input vec_t v);
        cur        = v;
        req_write  = v.wr;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_size   = v.size;
        req_signed = v.sgn;
        req_valid  = 1'b1;
    endtask

    task automatic send(input vec_t v);
        int t;
        @(posedge clk);
        #1 drive(v);
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready)
            fail("accept_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            fail("resp_timeout");
            q.delete();
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_mis"}, {31'd0, resp_misaligned}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_memread"}, {31'd0, mem_memread}, 32'd0);
        chk({tag, "_memwrite"}, {31'd0, mem_memwrite}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
        chk({tag, "_sign_mask"}, {28'd0, mem_sign_mask}, 32'd0);
    endtask

    vec_t vecs[12];
    vec_t va;
    vec_t vb;
    int   acc1;
    int   t;

    initial begin
        //        wr    addr          wdata         size   sgn   mdata         mis   mask
        vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0,        2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'b0111};
        vecs[1]  = '{1'b0, 32'h0000_1003, 32'h0,        2'b00, 1'b1, 32'hFFFF_FFEF, 1'b0, 4'b1001};
        vecs[2]  = '{1'b1, 32'h0000_1006, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0,        1'b0, 4'b0011};
        vecs[3]  = '{1'b0, 32'h0000_1002, 32'h0,        2'b10, 1'b0, 32'h1111_1111, 1'b1, 4'b0000};
        vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,        2'b11, 1'b0, 32'h2222_2222, 1'b1, 4'b0000};
        vecs[5]  = '{1'b1, 32'h0000_2000, 32'h0000_00FF, 2'b10, 1'b0, 32'h0,        1'b0, 4'b0111};
        vecs[6]  = '{1'b0, 32'h0000_1002, 32'h0,        2'b01, 1'b1, 32'hFFFF_8001, 1'b0, 4'b1011};
        vecs[7]  = '{1'b1, 32'h0000_1001, 32'h0000_005A, 2'b00, 1'b1, 32'h0,        1'b0, 4'b0001};
        vecs[8]  = '{1'b0, 32'h0000_1001, 32'h0,        2'b01, 1'b0, 32'h3333_3333, 1'b1, 4'b0000};
        vecs[9]  = '{1'b1, 32'h0000_1003, 32'h1234_5678, 2'b10, 1'b0, 32'h0,        1'b1, 4'b0000};
        vecs[10] = '{1'b0, 32'h0000_2000, 32'h0,        2'b10, 1'b1, 32'h1234_5678, 1'b0, 4'b1111};
        vecs[11] = '{1'b0, 32'h0000_1000, 32'h0,        2'b00, 1'b0, 32'h0000_00AB, 1'b0, 4'b0001};

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        req_size      = 2'b00;
        req_signed    = 1'b0;
        mem_read_data = 32'd0;
        cur           = vecs[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i]);
            drain();
        end

        // Held-valid back-to-back loads
        va = vecs[0];
        vb = vecs[11];
        last_resp = -1;
        @(posedge clk);
        #1 drive(va);
        t = 0;
        while (last_acc < 0 || q.size() == 0) begin
            @(posedge clk);
            t++;
            if (t > 50) break;
        end
        acc1 = last_acc;
        #1 drive(vb);
        t = 0;
        while (last_acc == acc1 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1 req_valid = 1'b0;
        if (last_acc == acc1)
            fail("b2b_second_accept");
        else
            chk("b2b_gap", last_acc, last_resp + 1);
        drain();

        // Reset during the WAIT phase of a load
        send(vecs[0]);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_first_memread", {31'd0, mem_memread}, 32'd0);
        chk("rst_first_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_first_resp", {31'd0, resp_valid}, 32'd0);
        q.delete();
        @(negedge clk);
        chk_reset_outputs("mid");
        @(posedge clk);
        #1 begin
            reset = 1'b0;
            drive(vecs[2]);
        end
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
        repeat (8) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
